song_memory_bank: RTL and testbench

//  Parametrised multi-slot note store; successor to the two-memory autoplay/learning unit.

---
 rtl/song_memory_bank_pkg.sv | 26 ++
 rtl/song_memory_bank_ram.sv | 22 ++
 rtl/song_memory_bank.sv | 116 +++++++++++
 tb/tb_song_memory_bank.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/song_memory_bank_pkg.sv
// Shared encodings for the song memory bank: mode codes, FSM state codes, default sizes.
package song_memory_bank_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_RECORD = 2'b01;
    localparam logic [1:0] MODE_PLAY   = 2'b10;
    localparam logic [1:0] MODE_LOOP   = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REC  = 2'b01;
    localparam logic [1:0] S_PLAY = 2'b10;
    localparam logic [1:0] S_END  = 2'b11;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_DEPTH   = 64;
    localparam int unsigned DEF_N_SLOTS = 4;

    function automatic logic [1:0] mode_to_state(input logic [1:0] m);
        logic [1:0] s;
        s = S_PLAY;
        if (m == MODE_IDLE) s = S_IDLE;
        else if (m == MODE_RECORD) s = S_REC;
        return s;
    endfunction

endpackage

// File: rtl/song_memory_bank_ram.sv
// Simple dual-port note RAM: one write port, one registered read port, no reset.
module song_memory_bank_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/song_memory_bank.sv
// Multi-slot song store: record (append), one-shot playback and looped playback per slot.
module song_memory_bank
    import song_memory_bank_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned N_SLOTS = DEF_N_SLOTS,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned SLOT_W = $clog2(N_SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [SLOT_W-1:0] slot_sel,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic              rd_rst,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              full,
    output logic              overflow,
    output logic [ADDR_W:0]   length
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q;
    logic [SLOT_W-1:0] slot_q;
    logic [ADDR_W:0]   len_q [N_SLOTS];
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              valid_q, ovf_q;
    logic [DATA_W-1:0] hold_q, ram_rdata;

    logic rewind, rd_go, at_end, rd_hit, loop_wrap, play_end;
    logic wr_go, clear_go, ram_re;
    logic [ADDR_W-1:0] rd_addr;

    assign length = len_q[slot_sel];
    assign full   = (length == (ADDR_W+1)'(DEPTH));

    assign rewind    = rd_rst || (mode != mode_q) || (slot_sel != slot_q);
    assign rd_go     = (state_q == S_PLAY) && rd_req && !rewind;
    assign at_end    = (rd_ptr_q == length);
    assign rd_hit    = rd_go && !at_end;
    assign loop_wrap = rd_go && at_end && (mode == MODE_LOOP) && (length != '0);
    assign play_end  = rd_go && at_end && (mode == MODE_PLAY);
    assign ram_re    = rd_hit || loop_wrap;
    assign rd_addr   = loop_wrap ? '0 : rd_ptr_q[ADDR_W-1:0];

    assign wr_go    = (state_q == S_REC) && wr_en && !full;
    assign clear_go = (state_q == S_IDLE) && clear;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (rewind) rd_ptr_d = '0;
        else if (rd_hit) rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
        else if (loop_wrap) rd_ptr_d = (ADDR_W+1)'(1);
    end

    // S_END survives only while the listener stays on the same PLAY slot.
    always_comb begin
        state_d = mode_to_state(mode);
        if (state_q == S_END && mode == MODE_PLAY && slot_sel == slot_q && !rd_rst)
            state_d = S_END;
        if (play_end) state_d = S_END;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_IDLE;
            slot_q   <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            hold_q   <= '0;
            for (int i = 0; i < N_SLOTS; i++) len_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode;
            slot_q   <= slot_sel;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= ram_re;
            ovf_q    <= (state_q == S_REC) && wr_en && full;
            if (valid_q) hold_q <= ram_rdata;
            for (int i = 0; i < N_SLOTS; i++) begin
                if (slot_sel == SLOT_W'(i)) begin
                    if (clear_go) len_q[i] <= '0;
                    else if (wr_go) len_q[i] <= len_q[i] + (ADDR_W+1)'(1);
                end
            end
        end
    end

    song_memory_bank_ram #(
        .DATA_W (DATA_W),
        .AW     (SLOT_W + ADDR_W)
    ) u_ram (
        .clk    (clk),
        .we     (wr_go),
        .waddr  ({slot_sel, length[ADDR_W-1:0]}),
        .wdata  (wr_data),
        .re     (ram_re),
        .raddr  ({slot_sel, rd_addr}),
        .rdata  (ram_rdata)
    );

    // RAM output register has no reset, so idle cycles show the last captured note.
    assign rd_data  = valid_q ? ram_rdata : hold_q;
    assign rd_valid = valid_q;
    assign done     = (state_q == S_END);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_song_memory_bank.sv
// Scoreboard bench for song_memory_bank: expected notes queued at request, checked on rd_valid.
module tb_song_memory_bank;
    import song_memory_bank_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned SLOT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        mode = MODE_IDLE;
    logic [SLOT_W-1:0] slot_sel = '0;
    logic              clear = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_req = 1'b0;
    logic              rd_rst = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, done, full, overflow;
    logic [ADDR_W:0]   length;

    int n_checks = 0;
    int n_fails  = 0;
    logic [DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    song_memory_bank #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .N_SLOTS (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .slot_sel (slot_sel),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_rst   (rd_rst),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .done     (done),
        .full     (full),
        .overflow (overflow),
        .length   (length)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] m, input int s);
        mode = m;
        slot_sel = SLOT_W'(s);
        tick();
    endtask

    function automatic logic [DATA_W-1:0] pat(input int i);
        return DATA_W'((i * 7) + 5);
    endfunction

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rd_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL unexpected_rd_valid: got 0x%0h, expected no note", rd_data);
                    end else begin
                        check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        // 1: reset state
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int s = 0; s < 4; s++) begin
            slot_sel = SLOT_W'(s);
            #1;
            check("reset_length", int'(length), 0);
            check("reset_full", int'(full), 0);
        end
        check("reset_done", int'(done), 0);
        check("reset_rd_valid", int'(rd_valid), 0);
        check("reset_rd_data", int'(rd_data), 0);

        // 2: record three notes into slot 1, play them once
        go(MODE_RECORD, 1);
        wr_en = 1'b1;
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_en = 1'b0;
        check("rec_length", int'(length), 3);
        go(MODE_PLAY, 1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        rd_req = 1'b1;
        repeat (4) tick();
        rd_req = 1'b0;
        check("play_done", int'(done), 1);
        tick();
        check("play_done_held", int'(done), 1);

        // 3: fill slot 2 past capacity
        go(MODE_RECORD, 2);
        wr_en = 1'b1;
        for (int i = 0; i < 65; i++) begin
            wr_data = pat(i);
            tick();
            if (i == 63) check("no_early_overflow", int'(overflow), 0);
        end
        check("overflow_pulse", int'(overflow), 1);
        wr_en = 1'b0;
        tick();
        check("overflow_single", int'(overflow), 0);
        check("full_length", int'(length), 64);
        check("full_flag", int'(full), 1);
        go(MODE_PLAY, 2);
        rd_req = 1'b1;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(pat(i));
            tick();
        end
        tick();
        rd_req = 1'b0;
        check("full_play_done", int'(done), 1);

        // 4: loop slot 1
        go(MODE_LOOP, 1);
        rd_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back((i % 3 == 0) ? 8'h11 : (i % 3 == 1) ? 8'h22 : 8'h33);
            tick();
        end
        rd_req = 1'b0;
        check("loop_done", int'(done), 0);

        // 5: rewind mid-song, then slot switch
        go(MODE_PLAY, 1);
        rd_req = 1'b1;
        exp_q.push_back(8'h11); tick();
        exp_q.push_back(8'h22); tick();
        rd_rst = 1'b1; tick();
        rd_rst = 1'b0;
        exp_q.push_back(8'h11); tick();
        rd_req = 1'b0;
        slot_sel = 2'd2;
        rd_req = 1'b1;
        tick();
        exp_q.push_back(pat(0)); tick();
        rd_req = 1'b0;
        tick();
        check("rewind_drained", exp_q.size(), 0);

        // 6: clear, empty loop, reset mid-play
        go(MODE_IDLE, 1);
        clear = 1'b1; tick();
        clear = 1'b0;
        check("clear_idle", int'(length), 0);
        go(MODE_RECORD, 2);
        clear = 1'b1; tick();
        clear = 1'b0;
        check("clear_rec_ignored", int'(length), 64);
        go(MODE_LOOP, 1);
        rd_req = 1'b1;
        repeat (3) tick();
        rd_req = 1'b0;
        check("loop_empty_done", int'(done), 0);

        go(MODE_RECORD, 3);
        wr_en = 1'b1; wr_data = 8'h5A; tick();
        wr_en = 1'b0;
        go(MODE_PLAY, 3);
        rd_req = 1'b1;
        exp_q.push_back(8'h5A); tick();
        rd_req = 1'b0;
        @(negedge clk);
        #1;
        check("pre_reset_valid", int'(rd_valid), 1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_valid", int'(rd_valid), 0);
        check("reset_clears_data", int'(rd_data), 0);
        check("reset_clears_length", int'(length), 0);
        tick();
        rst_n = 1'b1;

        go(MODE_RECORD, 3);
        wr_en = 1'b1; wr_data = 8'h5A; tick();
        wr_en = 1'b0;
        go(MODE_PLAY, 3);
        rd_req = 1'b1;
        exp_q.push_back(8'h5A);
        repeat (2) tick();
        rd_req = 1'b0;
        check("pre_reset_done", int'(done), 1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
